// File: rtl/bus_arbiter_pkg.sv
// Shared bus package, imported by the bus arbiter and the caches.
// Contents:
//   state_e      - arbiter FSM state (IDLE, BUSY)
//   beatsFor     - beats per block transfer (block words / words per beat)
//   idWidth      - width of a cache index, never less than one bit
//   beatCntWidth - width of a beat counter able to hold the full beat count
package bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // A block moves over the bus as a fixed number of memory beats.
  function automatic int beatsFor(input int blockWords, input int wordsPerBeat);
    return blockWords / wordsPerBeat;
  endfunction

  // A single cache still needs a one-bit index so that port widths stay legal.
  function automatic int idWidth(input int numCaches);
    return (numCaches > 1) ? $clog2(numCaches) : 1;
  endfunction

  // One extra bit so that the value "all beats done" fits.
  function automatic int beatCntWidth(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_sel.sv
// rr_priority_sel: purely combinational round-robin picker.
// Ports:
//   i_req    - request vector, one bit per cache
//   i_last   - index of the previous winner; the search starts just above it
//   o_oneHot - one-hot vector marking the winner (all zero if nobody asks)
//   o_idx    - binary index of the winner (zero if nobody asks)
//   o_any    - at least one request is pending
module rr_priority_sel #(
  parameter int width_p    = 4,
  parameter int id_width_p = 2
) (
  input  logic [width_p-1:0]    i_req,
  input  logic [id_width_p-1:0] i_last,
  output logic [width_p-1:0]    o_oneHot,
  output logic [id_width_p-1:0] o_idx,
  output logic                  o_any
);

  int   w_scan;
  logic w_found;

  // Walk the requesters starting one past the last winner and wrapping
  // around. The last winner itself is visited last, so it only wins again
  // when nobody else is asking. The first hit stops further updates.
  always_comb begin
    o_oneHot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_scan   = 0;
    for (int k = 1; k <= width_p; k++) begin
      w_scan = (int'(i_last) + k) % width_p;
      if (!w_found && i_req[w_scan]) begin
        w_found          = 1'b1;
        o_oneHot[w_scan] = 1'b1;
        o_idx            = id_width_p'(w_scan);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the shared memory bus to one cache at a time and
// tracks the beats of the block transfer that the owning cache performs.
// Ports:
//   clk_i        - clock; all state changes on the rising edge
//   reset_i      - synchronous active-high reset
//   cb_valid_i   - per-cache request, held until that cache sees yumi
//   cb_yumi_o    - one-hot accept pulse to the winning cache
//   mem_ready_i  - memory can start a new transaction
//   mem_valid_i  - memory completed one beat this cycle
//   grant_v_o    - a transaction currently owns the bus
//   grant_id_o   - index of the owning cache (drives the bus packet mux)
//   cb_valid_o   - beat-completion strobe, routed to the owner only
//   beat_cnt_o   - beats completed in the current transaction
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int  num_caches_p     = 4,
  parameter int  block_width_p    = 16,
  parameter int  dma_data_width_p = 2,
  localparam int beats_lp         = beatsFor(block_width_p, dma_data_width_p),
  localparam int id_w_lp          = idWidth(num_caches_p),
  localparam int cnt_w_lp         = beatCntWidth(beats_lp)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [num_caches_p-1:0] cb_valid_i,
  output logic [num_caches_p-1:0] cb_yumi_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_valid_i,
  output logic                    grant_v_o,
  output logic [id_w_lp-1:0]      grant_id_o,
  output logic [num_caches_p-1:0] cb_valid_o,
  output logic [cnt_w_lp-1:0]     beat_cnt_o
);

  localparam logic [num_caches_p-1:0] OneLsb = 1;

  state_e                  r_state;
  state_e                  w_nextState;
  logic [id_w_lp-1:0]      r_owner;
  logic [id_w_lp-1:0]      r_lastGrant;
  logic [cnt_w_lp-1:0]     r_beatCnt;
  logic [num_caches_p-1:0] w_rrOneHot;
  logic [id_w_lp-1:0]      w_rrIdx;
  logic                    w_rrAny;
  logic                    w_accept;
  logic                    w_beat;
  logic                    w_lastBeat;

  rr_priority_sel #(
    .width_p   (num_caches_p),
    .id_width_p(id_w_lp)
  ) uRrSel (
    .i_req   (cb_valid_i),
    .i_last  (r_lastGrant),
    .o_oneHot(w_rrOneHot),
    .o_idx   (w_rrIdx),
    .o_any   (w_rrAny)
  );

  // A new transaction starts only from IDLE, so the cycle carrying the final
  // beat (still BUSY) can never also carry a grant; that is what leaves the
  // one idle cycle between transactions.
  assign w_accept   = (r_state == IDLE) && mem_ready_i && w_rrAny;
  assign w_beat     = (r_state == BUSY) && mem_valid_i;
  assign w_lastBeat = w_beat && (r_beatCnt == cnt_w_lp'(beats_lp - 1));

  // State register of the two-process FSM.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE -> BUSY on an accepted request, BUSY -> IDLE
  // once the last beat of the block has been seen.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)   w_nextState = BUSY;
      BUSY:    if (w_lastBeat) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs. Everything is forced quiet while reset is held, including a
  // transaction that was in flight, so an abandoned transfer produces no
  // strobe. The beat count includes a beat completing in this very cycle,
  // which is how the final beat can be seen as the full count even though
  // the register itself clears on it.
  always_comb begin
    cb_yumi_o  = '0;
    grant_v_o  = 1'b0;
    grant_id_o = '0;
    cb_valid_o = '0;
    beat_cnt_o = '0;
    if (!reset_i) begin
      beat_cnt_o = r_beatCnt;
      if (w_accept) begin
        cb_yumi_o = w_rrOneHot;
      end
      if (r_state == BUSY) begin
        grant_v_o  = 1'b1;
        grant_id_o = r_owner;
      end
      if (w_beat) begin
        cb_valid_o = OneLsb << r_owner;
        beat_cnt_o = r_beatCnt + cnt_w_lp'(1);
      end
    end
  end

  // Owner, round-robin pointer and beat counter. The pointer resets to the
  // highest index so that cache 0 is first in line after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_owner     <= '0;
      r_lastGrant <= id_w_lp'(num_caches_p - 1);
      r_beatCnt   <= '0;
    end else if (w_accept) begin
      r_owner     <= w_rrIdx;
      r_lastGrant <= w_rrIdx;
      r_beatCnt   <= '0;
    end else if (w_lastBeat) begin
      r_beatCnt <= '0;
    end else if (w_beat) begin
      r_beatCnt <= r_beatCnt + cnt_w_lp'(1);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter with default
// parameters (4 caches, 8 beats per block). Expected yumi and beat strobes
// are queued as stimulus is driven and popped by a monitor when the DUT
// produces them.
module tb_bus_arbiter;

  logic       clk_i;
  logic       reset_i;
  logic [3:0] cb_valid_i;
  logic [3:0] cb_yumi_o;
  logic       mem_ready_i;
  logic       mem_valid_i;
  logic       grant_v_o;
  logic [1:0] grant_id_o;
  logic [3:0] cb_valid_o;
  logic [3:0] beat_cnt_o;

  int checkCount = 0;
  int passCount  = 0;

  logic [3:0] grantQ[$];
  logic [7:0] beatQ[$];

  bus_arbiter dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .cb_valid_i (cb_valid_i),
    .cb_yumi_o  (cb_yumi_o),
    .mem_ready_i(mem_ready_i),
    .mem_valid_i(mem_valid_i),
    .grant_v_o  (grant_v_o),
    .grant_id_o (grant_id_o),
    .cb_valid_o (cb_valid_o),
    .beat_cnt_o (beat_cnt_o)
  );

  // Free-running clock, period 10.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then return just
  // after the falling edge so the caller and the monitor see settled outputs.
  task automatic applyStimulus(input logic rst, input logic [3:0] req,
                               input logic ready, input logic memValid);
    @(posedge clk_i);
    #1;
    reset_i     = rst;
    cb_valid_i  = req;
    mem_ready_i = ready;
    mem_valid_i = memValid;
    @(negedge clk_i);
    #1;
  endtask

  // Monitor: every yumi and every beat strobe must match the head of its
  // queue; anything arriving with an empty queue is unexpected.
  always @(negedge clk_i) begin
    if (cb_yumi_o != 4'b0000) begin
      checkOutput("yumiOneHot", 32'($countones(cb_yumi_o)), 32'd1);
      if (grantQ.size() == 0) checkOutput("yumiUnexpected", {28'd0, cb_yumi_o}, 32'd0);
      else                    checkOutput("yumi", {28'd0, cb_yumi_o}, {28'd0, grantQ.pop_front()});
    end
    if (cb_valid_o != 4'b0000) begin
      if (beatQ.size() == 0) checkOutput("beatUnexpected", {28'd0, cb_valid_o}, 32'd0);
      else                   checkOutput("beat", {24'd0, cb_valid_o, beat_cnt_o}, {24'd0, beatQ.pop_front()});
    end
  end

  // One transaction: request until granted, then numBeats beats separated by
  // gap idle cycles. Requests stay asserted while busy, including the final
  // beat cycle, so any yumi there would be caught as unexpected. A complete
  // transaction is followed by one idle cycle with requests withdrawn.
  task automatic doTxn(input logic [3:0] req, input int expId, input int gap,
                       input int numBeats);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << expId;
    grantQ.push_back(oneHot);
    applyStimulus(1'b0, req, 1'b1, 1'b0);
    checkOutput("yumiSeen", 32'(grantQ.size()), 32'd0);
    grantQ.delete();
    for (int b = 0; b < numBeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, req, 1'b1, 1'b0);
        checkOutput("gapStrobe", {28'd0, cb_valid_o}, 32'd0);
        checkOutput("gapBusy", {31'd0, grant_v_o}, 32'd1);
      end
      beatQ.push_back({oneHot, 4'(b + 1)});
      applyStimulus(1'b0, req, 1'b1, 1'b1);
      checkOutput("beatSeen", 32'(beatQ.size()), 32'd0);
      beatQ.delete();
      checkOutput("busyId", {30'd0, grant_id_o}, 32'(expId));
    end
    if (numBeats == 8) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      checkOutput("idleGrantV", {31'd0, grant_v_o}, 32'd0);
      checkOutput("idleGrantId", {30'd0, grant_id_o}, 32'd0);
      checkOutput("idleCnt", {28'd0, beat_cnt_o}, 32'd0);
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    cb_valid_i  = 4'b0000;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;

    // Reset held with requests pending: everything stays quiet.
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    checkOutput("rstYumi", {28'd0, cb_yumi_o}, 32'd0);
    checkOutput("rstGrantV", {31'd0, grant_v_o}, 32'd0);
    checkOutput("rstGrantId", {30'd0, grant_id_o}, 32'd0);
    checkOutput("rstStrobe", {28'd0, cb_valid_o}, 32'd0);
    checkOutput("rstCnt", {28'd0, beat_cnt_o}, 32'd0);

    // Everyone requesting: strict rotation 0,1,2,3,0; owner 2 gets gaps.
    doTxn(4'b1111, 0, 0, 8);
    doTxn(4'b1111, 1, 0, 8);
    doTxn(4'b1111, 2, 2, 8);
    doTxn(4'b1111, 3, 0, 8);
    doTxn(4'b1111, 0, 0, 8);

    // Last grant was 0: with caches 0 and 3 asking, 3 wins, then 0.
    doTxn(4'b1001, 3, 0, 8);
    doTxn(4'b1001, 0, 1, 8);

    // Memory not ready: no acceptance for five cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0);
      checkOutput("notReadyYumi", {28'd0, cb_yumi_o}, 32'd0);
      checkOutput("notReadyGrantV", {31'd0, grant_v_o}, 32'd0);
    end
    doTxn(4'b0110, 1, 0, 8);

    // Stray memory beat while idle is ignored.
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    checkOutput("spurStrobe", {28'd0, cb_valid_o}, 32'd0);
    checkOutput("spurCnt", {28'd0, beat_cnt_o}, 32'd0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("spurCntAfter", {28'd0, beat_cnt_o}, 32'd0);

    // Reset in the middle of a transaction after three beats.
    doTxn(4'b0100, 2, 0, 3);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b1);
    checkOutput("midRstStrobe", {28'd0, cb_valid_o}, 32'd0);
    checkOutput("midRstGrantV", {31'd0, grant_v_o}, 32'd0);
    checkOutput("midRstCnt", {28'd0, beat_cnt_o}, 32'd0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    checkOutput("postRstGrantV", {31'd0, grant_v_o}, 32'd0);
    checkOutput("postRstGrantId", {30'd0, grant_id_o}, 32'd0);
    checkOutput("postRstStrobe", {28'd0, cb_valid_o}, 32'd0);
    checkOutput("postRstCnt", {28'd0, beat_cnt_o}, 32'd0);
    doTxn(4'b1111, 0, 0, 8);

    checkOutput("grantQDrained", 32'(grantQ.size()), 32'd0);
    checkOutput("beatQDrained", 32'(beatQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter num_caches_p, default 4: number of requesting caches (1..16).
REQ-002 Parameter block_width_p, default 16: cache block size in 32-bit words.
REQ-003 Parameter dma_data_width_p, default 2: words per memory beat; beats_lp = block_width_p/dma_data_width_p (default 8).
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 cb_valid_i  input  num_caches_p  per-cache bus request pending (level, held until yumi).
REQ-007 cb_yumi_o  output  num_caches_p  one-hot accept pulse to the winning cache.
REQ-008 mem_ready_i  input  1  memory can accept a new transaction.
REQ-009 mem_valid_i  input  1  memory beat completed this cycle.
REQ-010 grant_v_o  output  1  a transaction owns the bus.
REQ-011 grant_id_o  output  max(1,$clog2(num_caches_p))  index of owning cache; selects the bus packet mux.
REQ-012 cb_valid_o  output  num_caches_p  beat-completion strobe routed to the owner only.
REQ-013 beat_cnt_o  output  $clog2(beats_lp)+1  beats completed in current transaction.

Function
REQ-014 FSM states: IDLE, BUSY; encoding is free.
REQ-015 IDLE: when |cb_valid_i and mem_ready_i, select winner, assert cb_yumi_o[winner] combinationally in that cycle, go BUSY next cycle.
REQ-016 IDLE with no request or mem_ready_i=0: cb_yumi_o=0, remain IDLE.
REQ-017 Winner = first set cb_valid_i bit scanning from (last_grant+1) mod num_caches_p upward with wrap-around (round-robin).
REQ-018 On accept: owner register <= winner, last_grant <= winner, beat counter <= 0.
REQ-019 BUSY: grant_v_o=1, grant_id_o=owner; cb_yumi_o=0 regardless of requests or mem_ready_i.
REQ-020 BUSY: each mem_valid_i cycle increments beat counter and drives cb_valid_o[owner]=1 same cycle; other bits 0.
REQ-021 BUSY: mem_valid_i with counter==beats_lp-1 is the final beat; go IDLE next cycle, counter <= 0.
REQ-022 Minimum gap: one IDLE cycle between consecutive transactions; no back-to-back grant in the final-beat cycle.
REQ-023 mem_valid_i in IDLE is ignored: cb_valid_o stays 0, counter unchanged.
REQ-024 Requester dropping cb_valid_i before yumi is legal; it simply loses eligibility.
REQ-025 Owner's cb_valid_i during BUSY has no effect on the current transaction.
REQ-026 grant_v_o=0 and grant_id_o=0 in IDLE.
REQ-027 num_caches_p=1: arbitration degenerates to the single requester; grant_id_o constant 0.

Reset
REQ-028 reset_i asserted: next edge forces IDLE, counter=0, owner=0, last_grant=num_caches_p-1 (cache 0 wins first).
REQ-029 While reset_i=1: cb_yumi_o=0, cb_valid_o=0, grant_v_o=0, grant_id_o=0, beat_cnt_o=0.
REQ-030 Reset during BUSY abandons the transaction with no further strobes; no completion is reported.

Structure
REQ-031 beats_lp, state enum and id width function belong in the shared bus package used by bus and cache.
REQ-032 Round-robin selection is one combinational sub-module, rr_priority_sel (req vector, last index -> one-hot, index, any).
REQ-033 Counter, FSM and owner/last_grant registers live in bus_arbiter; no memory datapath inside.

Verification
REQ-034 After reset, cb_valid_i=4'b1111, mem_ready_i=1 -> grant order 0,1,2,3,0; each yumi one-hot, one cycle.
REQ-035 Owner 2, 8 mem_valid_i pulses with gaps -> cb_valid_o=4'b0100 on each, beat_cnt_o 1..8, IDLE after 8th.
REQ-036 cb_valid_i=4'b1001 with last_grant=0 -> cache 3 granted; next transaction cache 0.
REQ-037 Requests pending, mem_ready_i=0 for 5 cycles -> no yumi, grant_v_o=0; first cycle mem_ready_i=1 -> yumi.
REQ-038 Spurious mem_valid_i in IDLE -> cb_valid_o=0, beat_cnt_o=0.
REQ-039 reset_i after 3 beats of a transaction -> IDLE, all outputs 0 next cycle, next grant to cache 0.
